// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle MIPS-subset controller: opcodes,
// state encodings, datapath mux/ALU encodings and the control word layout.
package multicycle_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Controller states; encodings 12-15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  // ALUOp encodings, shared with alu_control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand B mux select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source mux select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full set of datapath control strobes produced per state
  typedef struct packed {
    logic       pc_write;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       memto_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
// MULTICYCLE_MEM_WAIT_EN adds the MemReady handshake from memory.
interface multicycle_control_if #(
  parameter int STATE_WIDTH = 4,
  parameter int OP_WIDTH    = 6
);
  logic [OP_WIDTH-1:0]    Opcode;
  logic                   Zero;
`ifdef MULTICYCLE_MEM_WAIT_EN
  logic                   MemReady;
`endif
  logic                   PCWrite;
  logic                   IorD;
  logic                   MemRead;
  logic                   MemWrite;
  logic                   IRWrite;
  logic                   MemtoReg;
  logic                   RegDst;
  logic                   RegWrite;
  logic                   ALUSrcA;
  logic [1:0]             ALUSrcB;
  logic [1:0]             ALUOp;
  logic [1:0]             PCSource;
  logic                   BadOpcode;
  logic [STATE_WIDTH-1:0] State;

  modport master (
`ifdef MULTICYCLE_MEM_WAIT_EN
    input  MemReady,
`endif
    input  Opcode, Zero,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, BadOpcode, State
  );

  modport slave (
`ifdef MULTICYCLE_MEM_WAIT_EN
    output MemReady,
`endif
    output Opcode, Zero,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, BadOpcode, State
  );

endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational state -> control word lookup. Only BRANCH looks at Zero and
// only FETCH looks at mem_ready (tied high when memory never stalls).
module multicycle_control_decode
  import multicycle_pkg::*;
(
  input  state_t state_i,
  input  logic   zero_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  // Per-state control strobes; everything not listed stays deasserted
  always_comb begin
    ctrl_o = CTRL_IDLE;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        // PC/IR update only on the cycle the fetch completes, so a stalled
        // fetch advances the PC exactly once
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.memto_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.ior_d     = 1'b1;
      end
      S_RTEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_RTWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_source = PCSRC_ALUOUT;
        ctrl_o.pc_write  = zero_i;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        ctrl_o.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset main controller: state register plus next-state
// logic; control strobes come from multicycle_control_decode.
// Optional: MULTICYCLE_MEM_WAIT_EN stalls FETCH/MEMRD/MEMWR on MemReady.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int STATE_WIDTH = 4,
  parameter int OP_WIDTH    = 6
) (
  input  logic                clock,
  input  logic                reset,
  multicycle_control_if.master bus
);

  state_t     state_q;
  state_t     state_d;
  logic       bad_opcode;
  logic       mem_ready;
  logic [5:0] opcode;
  ctrl_t      ctrl;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_ready = bus.MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  assign opcode = bus.Opcode[OP_WIDTH-1 -: 6];

  // State register; reset aborts any instruction and restarts at FETCH
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state selection and the DECODE-time illegal opcode flag
  always_comb begin
    state_d    = S_FETCH;
    bad_opcode = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTEX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d    = S_FETCH;
            bad_opcode = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTEX:   state_d = S_RTWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  multicycle_control_decode u_decode (
    .state_i     (state_q),
    .zero_i      (bus.Zero),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  assign bus.PCWrite   = ctrl.pc_write;
  assign bus.IorD      = ctrl.ior_d;
  assign bus.MemRead   = ctrl.mem_read;
  assign bus.MemWrite  = ctrl.mem_write;
  assign bus.IRWrite   = ctrl.ir_write;
  assign bus.MemtoReg  = ctrl.memto_reg;
  assign bus.RegDst    = ctrl.reg_dst;
  assign bus.RegWrite  = ctrl.reg_write;
  assign bus.ALUSrcA   = ctrl.alu_src_a;
  assign bus.ALUSrcB   = ctrl.alu_src_b;
  assign bus.ALUOp     = ctrl.alu_op;
  assign bus.PCSource  = ctrl.pc_source;
  assign bus.BadOpcode = bad_opcode;
  assign bus.State     = STATE_WIDTH'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-opcode state sequences, branch
// Zero handling, bad opcode, async reset mid-instruction, and (when
// MULTICYCLE_MEM_WAIT_EN is defined) memory stall behaviour.
module tb_multicycle_control;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  multicycle_control_if #(.STATE_WIDTH(4), .OP_WIDTH(6)) bus ();

  multicycle_control #(.STATE_WIDTH(4), .OP_WIDTH(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Expected state sequence and per-cycle snapshots of the strobes
  int         exp_st [6];
  logic [5:0] rec_pcw, rec_rw, rec_mw, rec_m2r, rec_rdst, rec_iord, rec_bad;
  logic [1:0] rec_pcsrc [6];
  logic [1:0] rec_aluop [6];
  logic [1:0] rec_srcb  [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Walk n states, checking State each cycle and snapshotting outputs for
  // every cycle except the final return to FETCH
  task automatic run_seq(input string tag, input int n);
    rec_pcw = '0; rec_rw = '0; rec_mw = '0; rec_m2r = '0;
    rec_rdst = '0; rec_iord = '0; rec_bad = '0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk({tag, "_state"}, 32'(bus.State), exp_st[i]);
      if (i < n - 1) begin
        rec_pcw[i]   = bus.PCWrite;
        rec_rw[i]    = bus.RegWrite;
        rec_mw[i]    = bus.MemWrite;
        rec_m2r[i]   = bus.MemtoReg;
        rec_rdst[i]  = bus.RegDst;
        rec_iord[i]  = bus.IorD;
        rec_bad[i]   = bus.BadOpcode;
        rec_pcsrc[i] = bus.PCSource;
        rec_aluop[i] = bus.ALUOp;
        rec_srcb[i]  = bus.ALUSrcB;
        tick();
      end
    end
    $display("[TB] %s sequence done", tag);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.Opcode = 6'b000000;
    bus.Zero = 1'b0;
`ifdef MULTICYCLE_MEM_WAIT_EN
    bus.MemReady = 1'b1;
`endif
    repeat (2) tick();

    // Reset holds FETCH with FETCH outputs
    chk("rst_state",    32'(bus.State), 0);
    chk("rst_memread",  32'(bus.MemRead), 1);
    chk("rst_pcwrite",  32'(bus.PCWrite), 1);
    chk("rst_irwrite",  32'(bus.IRWrite), 1);
    chk("rst_alusrcb",  32'(bus.ALUSrcB), 1);
    chk("rst_regwrite", 32'(bus.RegWrite), 0);
    $display("[TB] reset state checked");
    reset = 1'b0;

    // LW: 0,1,2,3,4 then FETCH
    bus.Opcode = 6'b100011;
    exp_st = '{0, 1, 2, 3, 4, 0};
    run_seq("lw", 6);
    chk("lw_pcw_pulses", 32'($countones(rec_pcw)), 1);
    chk("lw_regwrite",   32'(rec_rw), 32'h10);
    chk("lw_memtoreg",   32'(rec_m2r), 32'h10);
    chk("lw_iord",       32'(rec_iord), 32'h08);
    chk("lw_memwrite",   32'(rec_mw), 0);

    // SW: 0,1,2,5 then FETCH
    bus.Opcode = 6'b101011;
    exp_st = '{0, 1, 2, 5, 0, 0};
    run_seq("sw", 5);
    chk("sw_memwrite", 32'(rec_mw), 32'h08);
    chk("sw_regwrite", 32'(rec_rw), 0);
    chk("sw_srcb_adr", 32'(rec_srcb[2]), 2);

    // BEQ taken
    bus.Opcode = 6'b000100;
    bus.Zero = 1'b1;
    exp_st = '{0, 1, 8, 0, 0, 0};
    run_seq("beq_z1", 4);
    chk("beq_z1_pcw",    32'(rec_pcw), 32'h05);
    chk("beq_z1_pcsrc",  32'(rec_pcsrc[2]), 1);
    chk("beq_z1_aluop",  32'(rec_aluop[2]), 1);
    chk("beq_dec_srcb",  32'(rec_srcb[1]), 3);

    // BEQ not taken
    bus.Zero = 1'b0;
    run_seq("beq_z0", 4);
    chk("beq_z0_pcw", 32'(rec_pcw), 32'h01);

    // J
    bus.Opcode = 6'b000010;
    exp_st = '{0, 1, 9, 0, 0, 0};
    run_seq("j", 4);
    chk("j_pcw",   32'(rec_pcw), 32'h05);
    chk("j_pcsrc", 32'(rec_pcsrc[2]), 2);

    // R-type
    bus.Opcode = 6'b000000;
    exp_st = '{0, 1, 6, 7, 0, 0};
    run_seq("r", 5);
    chk("r_aluop",    32'(rec_aluop[2]), 2);
    chk("r_regwrite", 32'(rec_rw), 32'h08);
    chk("r_regdst",   32'(rec_rdst), 32'h08);

    // ADDI
    bus.Opcode = 6'b001000;
    exp_st = '{0, 1, 10, 11, 0, 0};
    run_seq("addi", 5);
    chk("addi_regwrite", 32'(rec_rw), 32'h08);
    chk("addi_regdst",   32'(rec_rdst), 0);
    chk("addi_srcb",     32'(rec_srcb[2]), 2);

    // Unknown opcode
    bus.Opcode = 6'b111111;
    exp_st = '{0, 1, 0, 0, 0, 0};
    run_seq("bad", 3);
    chk("bad_pulse",    32'(rec_bad), 32'h02);
    chk("bad_regwrite", 32'(rec_rw), 0);
    chk("bad_memwrite", 32'(rec_mw), 0);

`ifdef MULTICYCLE_MEM_WAIT_EN
    // Stalled FETCH: PC/IR not written until MemReady
    bus.Opcode = 6'b101011;
    bus.MemReady = 1'b0;
    #1;
    chk("mw_fetch_state", 32'(bus.State), 0);
    chk("mw_fetch_pcw0",  32'(bus.PCWrite), 0);
    chk("mw_fetch_irw0",  32'(bus.IRWrite), 0);
    chk("mw_fetch_mr",    32'(bus.MemRead), 1);
    tick();
    chk("mw_fetch_hold",  32'(bus.State), 0);
    bus.MemReady = 1'b1;
    #1;
    chk("mw_fetch_pcw1",  32'(bus.PCWrite), 1);
    tick();
    chk("mw_decode", 32'(bus.State), 1);
    tick();
    chk("mw_memadr", 32'(bus.State), 2);
    tick();
    bus.MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_memwr_wait_state", 32'(bus.State), 5);
      chk("mw_memwr_wait_mw",    32'(bus.MemWrite), 1);
      chk("mw_memwr_wait_pcw",   32'(bus.PCWrite), 0);
      tick();
    end
    bus.MemReady = 1'b1;
    #1;
    chk("mw_memwr_last", 32'(bus.MemWrite), 1);
    tick();
    chk("mw_back_fetch", 32'(bus.State), 0);
    $display("[TB] memory wait sequence done");
`endif

    // Async reset in the middle of MEMRD
    bus.Opcode = 6'b100011;
    repeat (3) tick();
    chk("mid_memrd", 32'(bus.State), 3);
    reset = 1'b1;
    #1;
    chk("mid_rst_async",  32'(bus.State), 0);
    chk("mid_rst_memw",   32'(bus.MemWrite), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_state", 32'(bus.State), 0);
    chk("post_rst_mr",    32'(bus.MemRead), 1);
    chk("post_rst_pcw",   32'(bus.PCWrite), 1);
    chk("post_rst_rw",    32'(bus.RegWrite), 0);
    chk("post_rst_mw",    32'(bus.MemWrite), 0);
    tick();
    chk("post_rst_next",  32'(bus.State), 1);
    $display("[TB] reset mid-instruction checked");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
